// File: rtl/arb_pkg.sv
// arb_pkg: shared types and sizes for the round-robin grant arbiter
package arb_pkg;
  typedef enum logic {IDLE, GRANT} arb_state_t;
  localparam int ARB_N = 4;
  localparam int ARB_IDX_W = 2;
endpackage

// File: rtl/decoder2to4.sv
// decoder2to4: enabled 2-to-4 one-hot decoder driven by the arbiter grant
module decoder2to4 (
  input  logic [1:0] A,
  input  logic       E,
  output logic [3:0] Y
);
  assign Y = E ? 4'b0001 << A : 4'b0000;
endmodule

// File: rtl/rr_pick4.sv
// rr_pick4: first asserted request at or after start, wrapping modulo 4
module rr_pick4
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]     req,
  input  logic [ARB_IDX_W-1:0] start,
  output logic [ARB_IDX_W-1:0] idx,
  output logic                 any
);
  logic [ARB_N-1:0]     rot;
  logic [ARB_IDX_W-1:0] off;
  // rotate so start sits at bit 0, then priority-encode the offset back
  always_comb begin
    rot = ARB_N'({req, req} >> start);
    off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    idx = start + off;
    any = |req;
  end
endmodule

// File: rtl/rr_arb4_sel.sv
// rr_arb4_sel: four-way round-robin arbiter with hold timeout and registered grant index
module rr_arb4_sel
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ARB_N-1:0]     req,
  input  logic                 rel,
  output logic [ARB_IDX_W-1:0] sel,
  output logic                 en,
  output logic                 timeout
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  arb_state_t           state;
  logic [ARB_IDX_W-1:0] ptr;
  logic [HW-1:0]        hold_cnt;
  logic [ARB_IDX_W-1:0] start;
  logic [ARB_IDX_W-1:0] win;
  logic                 any;
  logic                 end_c;
  // search starts after the owner while granting, else at the rotation pointer
  always_comb begin
    start = (state == GRANT) ? sel + 2'd1 : ptr;
    end_c = rel || !req[sel] || hold_cnt == HOLD_LAST;
  end
  rr_pick4 u_pick (.req(req), .start(start), .idx(win), .any(any));
  // grant FSM; timeout flags an end caused purely by the hold counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      sel      <= '0;
      en       <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (state == IDLE) begin
        en <= any;
        if (any) begin
          sel      <= win;
          hold_cnt <= '0;
          state    <= GRANT;
        end
      end else if (end_c) begin
        ptr      <= sel + 2'd1;
        timeout  <= !rel && req[sel];
        hold_cnt <= '0;
        if (any) sel <= win;
        else begin
          en    <= 1'b0;
          state <= IDLE;
        end
      end else begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end
endmodule

// File: tb/tb_rr_arb4_sel.sv
// tb_rr_arb4_sel: directed scoreboard bench for the round-robin arbiter and decoder
module tb_rr_arb4_sel;
  typedef struct packed {
    logic       en;
    logic [1:0] sel;
    logic       to;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic       rel = 1'b0;
  logic [1:0] sel;
  logic       en;
  logic       timeout;
  logic [3:0] y;
  int         checks = 0;
  int         failures = 0;
  exp_t       q[$];

  rr_arb4_sel #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel),
    .sel(sel), .en(en), .timeout(timeout)
  );
  decoder2to4 u_dec (.A(sel), .E(en), .Y(y));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    logic [3:0] ey;
    ey = e.en ? (4'b0001 << e.sel) : 4'b0000;
    chk({tag, ".en"}, {3'b0, en}, {3'b0, e.en});
    chk({tag, ".sel"}, {2'b0, sel}, {2'b0, e.sel});
    chk({tag, ".timeout"}, {3'b0, timeout}, {3'b0, e.to});
    chk({tag, ".Y"}, y, ey);
  endtask

  task automatic step(input string tag, input logic [3:0] r, input logic l,
                      input logic e_en, input logic [1:0] e_sel, input logic e_to);
    exp_t e;
    req = r;
    rel = l;
    q.push_back('{en: e_en, sel: e_sel, to: e_to});
    @(posedge clk);
    #1;
    e = q.pop_front();
    check_outs(tag, e);
  endtask

  task automatic do_reset();
    req = 4'b0;
    rel = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #3;
    check_outs("reset", '{en: 1'b0, sel: 2'd0, to: 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    step("single", 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
    step("single_drop", 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0);
    step("idle_hold", 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0);

    do_reset();
    step("all_first", 4'b1111, 1'b0, 1'b1, 2'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step("all_hold_a", 4'b1111, 1'b0, 1'b1, 2'(k), 1'b0);
      step("all_hold_b", 4'b1111, 1'b0, 1'b1, 2'(k), 1'b0);
      step("all_rotate", 4'b1111, 1'b1, 1'b1, 2'(k + 1), 1'b0);
    end
    step("all_drop", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

    do_reset();
    step("to_grant0", 4'b0011, 1'b0, 1'b1, 2'd0, 1'b0);
    for (int k = 0; k < 3; k++) step("to_hold0", 4'b0011, 1'b0, 1'b1, 2'd0, 1'b0);
    step("to_fire0", 4'b0011, 1'b0, 1'b1, 2'd1, 1'b1);
    for (int k = 0; k < 3; k++) step("to_hold1", 4'b0011, 1'b0, 1'b1, 2'd1, 1'b0);
    step("to_fire1", 4'b0011, 1'b0, 1'b1, 2'd0, 1'b1);

    step("sole_grant", 4'b1000, 1'b0, 1'b1, 2'd3, 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) step("sole_hold", 4'b1000, 1'b0, 1'b1, 2'd3, 1'b0);
      step("sole_fire", 4'b1000, 1'b0, 1'b1, 2'd3, 1'b1);
    end

    step("mid_grant2", 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
    step("mid_keep2", 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("mid_reset", '{en: 1'b0, sel: 2'd0, to: 1'b0});
    #2;
    rst_n = 1'b1;
    step("post_reset", 4'b0110, 1'b0, 1'b1, 2'd1, 1'b0);

    for (int k = 0; k < 3; k++) step("sim_hold", 4'b0110, 1'b0, 1'b1, 2'd1, 1'b0);
    step("sim_end", 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0);
    step("sim_after", 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
    step("sim_drop", 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0);
    step("idle_rel", 4'b0000, 1'b1, 1'b0, 2'd2, 1'b0);
    step("wrap_grant", 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rr_arb4_sel.md
# rr_arb4_sel

Four-requester round-robin arbiter that produces a registered 2-bit grant index plus enable. The outputs `sel` and `en` drive the `A[1:0]` and `E` inputs of the 2-to-4 decoder directly, so the decoder's `Y[3:0]` becomes the one-hot grant bus. Holds a grant until the owner releases or drops its request, or until a hold-timeout forces rotation, so no requester starves.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles one grant is held before a forced release; legal range 2..255.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  4  request vector; bit i is requester i, level-sensitive.
- `release`  input  1  single-cycle pulse from the current owner ending its grant.
- `sel`  output  2  registered index of the granted requester; feeds decoder `A`.
- `en`  output  1  registered grant-valid; feeds decoder `E`.
- `timeout`  output  1  registered one-cycle pulse marking a forced release.

## Operation
- State machine with states IDLE and GRANT.
- Internal state: `ptr[1:0]`, the search start index, and `hold_cnt` of width $clog2(MAX_HOLD+1).
- **Winner search:** scan `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4) and take the first asserted `req` bit.
- **IDLE:**
  - If `req` is nonzero: `sel` <= winner, `en` <= 1, `hold_cnt` <= 0, next state GRANT.
  - Otherwise: stay in IDLE with `en` = 0 and `sel` unchanged.
- **GRANT, end condition:** `release` = 1, or `req[sel]` = 0, or `hold_cnt` == MAX_HOLD-1.
- **GRANT, on the end condition:**
  - `ptr` <= `sel`+1 (mod 4).
  - Search from `sel`+1 using the current `req`.
  - If a winner exists: stay in GRANT, `sel` <= winner, `hold_cnt` <= 0.
  - If none: `en` <= 0, next state IDLE.
  - The current owner is re-granted only when it is the sole requester with `req[sel]` still 1.
- **GRANT, otherwise:** `hold_cnt` <= `hold_cnt`+1; `sel` and `en` are unchanged.
- **`timeout`:** 1 on the cycle after an end condition caused only by `hold_cnt` (no `release`, `req[sel]` still 1); 0 otherwise.
- `release` asserted while in IDLE is ignored.
- `req` changes on bits other than `sel` during GRANT have no effect until the next end condition.

## Timing
- **Reset values** (asynchronous, while `rst_n` = 0): `sel` = 0, `en` = 0, `timeout` = 0, `ptr` = 0, `hold_cnt` = 0, state IDLE.
- **Reset mid-grant:** the grant is dropped immediately, with no release cycle.
- **Grant latency:** `req` sampled at edge N while in IDLE gives `en` = 1 with a valid `sel` after edge N, i.e. one cycle.
- **Handover:** zero bubble. The old `sel` is valid through the cycle with the end condition and the new `sel` appears after the next edge; `en` stays 1.
- **Longest hold:** MAX_HOLD cycles of `en` = 1 for one `sel` value, then rotation if others are requesting.
- **Wrap-around:** when `sel` = 3, the next search starts at 0.
- **Simultaneous events:**
  - `release` together with `req[sel]` = 0 and the timeout count: treated as a release, so `timeout` = 0.
  - All four requesting: grants rotate 0, 1, 2, 3, 0 …
- `en` and `sel` change only on clock edges, so the decoder output is glitch-free relative to `clk`.

## Structure
- Shared package `arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, GRANT);
  - `ARB_N` = 4;
  - `ARB_IDX_W` = 2.
- One combinational sub-module, `rr_pick4`:
  - inputs: `req[3:0]`, `start[1:0]`;
  - outputs: `idx[1:0]`, `any`.
  - It is instantiated once. Its `start` is `ptr` in IDLE and `sel`+1 in GRANT.
- Top level: FSM, `ptr`, `hold_cnt`, output registers.
- The bench instantiates the existing `decoder2to4` downstream and checks `Y` = 1<<`sel` when `en` = 1, and `Y` = 0 otherwise.

## Test plan
- **Reset then single request:** release `rst_n`, set `req` = 4'b0100. Required: after one edge `en` = 1, `sel` = 2, `Y` = 4'b0100; with `req` = 0, `en` = 0 one cycle later.
- **All requesting with release pulses:** `req` = 4'b1111, pulse `release` every 3 cycles. Required: `sel` sequence 0, 1, 2, 3, 0 with `en` held at 1 throughout.
- **Timeout:** MAX_HOLD = 4, `req` = 4'b0011 held, no `release`. Required: `sel` = 0 for exactly 4 cycles, `timeout` pulses once, then `sel` = 1 for 4 cycles.
- **Sole requester timeout:** `req` = 4'b1000 held. Required: `sel` stays 3, `timeout` pulses every MAX_HOLD cycles, `en` never drops.
- **Reset mid-grant:** assert `rst_n` = 0 asynchronously between edges while `en` = 1, `sel` = 2. Required: `en` = 0 and `sel` = 0 immediately; after reset, `req` = 4'b0110 grants `sel` = 1 (`ptr` is back at 0).
- **Simultaneous end conditions:** at the timeout cycle also pulse `release`. Required: `timeout` stays 0 and the next grant goes to the following requester.
